key_conditioner: RTL and testbench

- Upstream front-end for the stopwatch datapath. It conditions the raw active-low DE1-SoC push-buttons and replaces direct negedge-key clocking with single-clock-domain signals.
- Per key it provides:
  - a 2-flop synchronizer;
  - a counter-based debounce;
  - one-cycle press, release and long-press pulses;
  - a toggle level: counter run/pause, display refresh/freeze, and reset request.

---
 rtl/key_conditioner.sv | 94 +++++++++
 tb/tb_key_conditioner.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// key_conditioner: turns raw active-low push-buttons into clean single-clock
// signals. Each key gets a 2-flop synchronizer, a counter debounce, one-cycle
// press/release/long-press pulses and a press-driven toggle level.
//
// Ports:
//   clk           - system clock, all state on rising edge
//   rst_n         - asynchronous active-low reset
//   key_n         - raw buttons, 0 = pressed, asynchronous to clk
//   key_state     - debounced level, 1 = pressed
//   press_pulse   - one cycle high on each debounced press
//   release_pulse - one cycle high on each debounced release
//   long_pulse    - one cycle high once per press held LONG_CYCLES
//   toggle        - level inverting on every press_pulse
module key_conditioner #(
    parameter int unsigned          NUM_KEYS        = 3,
    parameter int unsigned          DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned          LONG_CYCLES     = 100000000,
    parameter logic [NUM_KEYS-1:0]  TOGGLE_INIT     = NUM_KEYS'(3'b110)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] key_state,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse,
    output logic [NUM_KEYS-1:0] long_pulse,
    output logic [NUM_KEYS-1:0] toggle
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
    // One extra code point so the hold counter can park at LONG_CYCLES.
    localparam int unsigned HW = $clog2(LONG_CYCLES + 1);

    localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_SAT = HW'(LONG_CYCLES);

    logic [NUM_KEYS-1:0]         ff1;
    logic [NUM_KEYS-1:0]         ff2;
    logic [NUM_KEYS-1:0]         sync;
    logic [NUM_KEYS-1:0][DW-1:0] cnt;
    logic [NUM_KEYS-1:0][HW-1:0] hcnt;

    // Synchronized level, 1 = pressed.
    assign sync = ~ff2;

    // Synchronizer, debounce, pulse generation, toggle and hold counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff1           <= '1;
            ff2           <= '1;
            key_state     <= '0;
            press_pulse   <= '0;
            release_pulse <= '0;
            long_pulse    <= '0;
            toggle        <= TOGGLE_INIT;
            cnt           <= '0;
            hcnt          <= '0;
        end else begin
            ff1           <= key_n;
            ff2           <= ff1;
            press_pulse   <= '0;
            release_pulse <= '0;
            long_pulse    <= '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                // Any return to the accepted level restarts the debounce.
                if (sync[i] == key_state[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DEB_MAX) begin
                    cnt[i]           <= '0;
                    key_state[i]     <= sync[i];
                    press_pulse[i]   <= sync[i];
                    release_pulse[i] <= ~sync[i];
                    if (sync[i]) begin
                        toggle[i] <= ~toggle[i];
                    end
                end else begin
                    cnt[i] <= cnt[i] + DW'(1);
                end

                // Hold counter fires once then parks above HOLD_MAX until release.
                if (!key_state[i]) begin
                    hcnt[i] <= '0;
                end else if (hcnt[i] == HOLD_MAX) begin
                    hcnt[i]       <= HOLD_SAT;
                    long_pulse[i] <= 1'b1;
                end else if (hcnt[i] < HOLD_MAX) begin
                    hcnt[i] <= hcnt[i] + HW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with short debounce/long-press timing.
module tb_key_conditioner;

    localparam int unsigned NK = 3;

    logic          clk;
    logic          rst_n;
    logic [NK-1:0] key_n;
    logic [NK-1:0] key_state;
    logic [NK-1:0] press_pulse;
    logic [NK-1:0] release_pulse;
    logic [NK-1:0] long_pulse;
    logic [NK-1:0] toggle;

    int total;
    int bad;

    key_conditioner #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (4),
        .LONG_CYCLES     (8),
        .TOGGLE_INIT     (3'b110)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_n         (key_n),
        .key_state     (key_state),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .toggle        (toggle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        key_n = 3'b111;
        tick();
        tick();
        total++;
        if ({key_state, press_pulse, release_pulse, long_pulse} !== 12'h000) begin
            bad++;
            $display("FAIL reset_outputs: got ks=%b pp=%b rp=%b lp=%b want all 0",
                     key_state, press_pulse, release_pulse, long_pulse);
        end
        total++;
        if (toggle !== 3'b110) begin
            bad++;
            $display("FAIL reset_toggle: got %b want 110", toggle);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            total++;
            if ({key_state, press_pulse, release_pulse, long_pulse} !== 12'h000
                || toggle !== 3'b110) begin
                bad++;
                $display("FAIL reset_idle[%0d]: got ks=%b pp=%b rp=%b lp=%b tg=%b want 0/0/0/0/110",
                         k, key_state, press_pulse, release_pulse, long_pulse, toggle);
            end
        end
    endtask

    task automatic test_clean_press();
        key_n[1] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            total++;
            if (key_state[1] !== (k >= 5) || press_pulse[1] !== (k == 5)
                || release_pulse[1] !== 1'b0
                || toggle !== ((k >= 5) ? 3'b100 : 3'b110)) begin
                bad++;
                $display("FAIL press_E%0d: got ks=%b pp=%b rp=%b tg=%b want ks=%b pp=%b rp=0 tg=%b",
                         k, key_state[1], press_pulse[1], release_pulse[1], toggle,
                         (k >= 5), (k == 5), ((k >= 5) ? 3'b100 : 3'b110));
            end
        end
        key_n[1] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            total++;
            if (key_state[1] !== (k < 5) || release_pulse[1] !== (k == 5)
                || press_pulse[1] !== 1'b0 || toggle !== 3'b100) begin
                bad++;
                $display("FAIL release_R%0d: got ks=%b rp=%b pp=%b tg=%b want ks=%b rp=%b pp=0 tg=100",
                         k, key_state[1], release_pulse[1], press_pulse[1], toggle,
                         (k < 5), (k == 5));
            end
        end
    endtask

    task automatic test_bounce();
        logic [NK-1:0] pattern [15];
        for (int k = 0; k < 15; k++) pattern[k] = 3'b111;
        for (int k = 0; k < 3; k++) pattern[k] = 3'b110;
        for (int k = 4; k < 7; k++) pattern[k] = 3'b110;
        for (int k = 0; k < 15; k++) begin
            key_n = pattern[k];
            tick();
            total++;
            if (key_state[0] !== 1'b0 || press_pulse[0] !== 1'b0
                || release_pulse[0] !== 1'b0 || toggle !== 3'b100) begin
                bad++;
                $display("FAIL bounce[%0d]: got ks=%b pp=%b rp=%b tg=%b want 0/0/0/100",
                         k, key_state[0], press_pulse[0], release_pulse[0], toggle);
            end
        end
    endtask

    task automatic test_long_press();
        key_n[2] = 1'b0;
        for (int k = 0; k < 30; k++) begin
            tick();
            total++;
            if (press_pulse[2] !== (k == 5) || long_pulse[2] !== (k == 13)) begin
                bad++;
                $display("FAIL long_hold[%0d]: got pp=%b lp=%b want pp=%b lp=%b",
                         k, press_pulse[2], long_pulse[2], (k == 5), (k == 13));
            end
        end
        key_n[2] = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            total++;
            if (release_pulse[2] !== (k == 5) || long_pulse[2] !== 1'b0) begin
                bad++;
                $display("FAIL long_release[%0d]: got rp=%b lp=%b want rp=%b lp=0",
                         k, release_pulse[2], long_pulse[2], (k == 5));
            end
        end
        total++;
        if (toggle !== 3'b000) begin
            bad++;
            $display("FAIL long_toggle: got %b want 000", toggle);
        end
    endtask

    task automatic test_reset_mid_op();
        key_n[1] = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        rst_n = 1'b0;
        #1;
        total++;
        if (key_state !== 3'b000 || toggle !== 3'b110
            || {press_pulse, release_pulse, long_pulse} !== 9'h000) begin
            bad++;
            $display("FAIL midreset_clear: got ks=%b tg=%b pp=%b rp=%b lp=%b want 000/110/0/0/0",
                     key_state, toggle, press_pulse, release_pulse, long_pulse);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            total++;
            if (press_pulse[1] !== (k == 5) || key_state[1] !== (k >= 5)
                || toggle !== ((k >= 5) ? 3'b100 : 3'b110)) begin
                bad++;
                $display("FAIL midreset_E%0d: got pp=%b ks=%b tg=%b want pp=%b ks=%b tg=%b",
                         k, press_pulse[1], key_state[1], toggle, (k == 5), (k >= 5),
                         ((k >= 5) ? 3'b100 : 3'b110));
            end
        end
        key_n[1] = 1'b1;
        for (int k = 0; k < 8; k++) tick();
    endtask

    task automatic test_simultaneous();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        key_n = 3'b000;
        for (int k = 0; k < 8; k++) begin
            tick();
            total++;
            if (press_pulse !== ((k == 5) ? 3'b111 : 3'b000)
                || toggle !== ((k >= 5) ? 3'b001 : 3'b110)) begin
                bad++;
                $display("FAIL simul_press[%0d]: got pp=%b tg=%b want pp=%b tg=%b",
                         k, press_pulse, toggle, ((k == 5) ? 3'b111 : 3'b000),
                         ((k >= 5) ? 3'b001 : 3'b110));
            end
        end
        key_n = 3'b111;
        for (int k = 0; k < 8; k++) begin
            tick();
            total++;
            if (release_pulse !== ((k == 5) ? 3'b111 : 3'b000)
                || press_pulse !== 3'b000 || toggle !== 3'b001) begin
                bad++;
                $display("FAIL simul_release[%0d]: got rp=%b pp=%b tg=%b want rp=%b pp=000 tg=001",
                         k, release_pulse, press_pulse, toggle,
                         ((k == 5) ? 3'b111 : 3'b000));
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        key_n = 3'b111;
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_press();
        test_reset_mid_op();
        test_simultaneous();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
